// File: rtl/balancer_pkg.sv
// rtl/balancer_pkg.sv - shared FSM state type and index-width helper for the server balancer
package balancer_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_t;

  // Index width for a population of n items (n >= 2).
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/balancer_argmin.sv
// rtl/balancer_argmin.sv - least-loaded eligible server picker, ties go to first hit from start index
module balancer_argmin #(
  parameter int N     = 4,
  parameter int CNT_W = 4,
  parameter int IDX_W = 2
) (
  input  logic [N*CNT_W-1:0] counts,
  input  logic [N-1:0]       eligible,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   winner,
  output logic               any_eligible
);

  logic [CNT_W-1:0] best;
  int               pos;

  // Walk servers in wrap-around order from start; strict less-than keeps the earliest tie.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    best         = '1;
    pos          = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (eligible[pos] && (!any_eligible || counts[pos*CNT_W +: CNT_W] < best)) begin
        any_eligible = 1'b1;
        best         = counts[pos*CNT_W +: CNT_W];
        winner       = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/multi_server_balancer.sv
// rtl/multi_server_balancer.sv - dispatches task vectors to least-loaded servers; BALANCER_RR_TIE_EN enables round-robin ties
module multi_server_balancer
  import balancer_pkg::*;
#(
  parameter int NUM_SERVERS = 4,
  parameter int NUM_TASKS   = 8,
  parameter int CNT_W       = 4,
  parameter int THRESHOLD   = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [NUM_TASKS-1:0]            tasks,
  input  logic [NUM_SERVERS-1:0]          done,
  output logic                            dispatch_valid,
  output logic [$clog2(NUM_SERVERS)-1:0]  dispatch_server,
  output logic [$clog2(NUM_TASKS)-1:0]    dispatch_task,
  output logic [NUM_SERVERS*CNT_W-1:0]    server_count,
  output logic                            trigger,
  output logic                            overload
);

  localparam int SRV_W = idx_w(NUM_SERVERS);
  localparam int TASK_W = idx_w(NUM_TASKS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                       state_q, state_d;
  logic [NUM_TASKS-1:0]         pending_q, pending_clr;
  logic [CNT_W-1:0]             cnt_q [NUM_SERVERS];
  logic [NUM_SERVERS*CNT_W-1:0] cnt_flat;
  logic [NUM_SERVERS-1:0]       eligible, hot, inc_vec, dec_vec;
  logic [SRV_W-1:0]             tie_start, winner;
  logic [TASK_W-1:0]            top_task;
  logic                         any_eligible, fire, accept;

  always_comb begin
    cnt_flat = '0;
    eligible = '0;
    hot      = '0;
    for (int i = 0; i < NUM_SERVERS; i++) begin
      cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
      eligible[i] = (cnt_q[i] != CNT_MAX);
      hot[i]      = (32'(cnt_q[i]) > THRESHOLD);
    end
  end

  assign server_count = cnt_flat;
  assign trigger      = |hot;
  assign overload     = &hot;

  // Highest set pending bit is served first.
  always_comb begin
    top_task = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      if (pending_q[i]) top_task = TASK_W'(i);
    end
  end

  assign pending_clr = pending_q & ~(NUM_TASKS'(1) << top_task);
  assign fire        = (state_q == DISPATCH) && any_eligible;
  assign accept      = load_valid && load_ready;

  balancer_argmin #(
    .N     (NUM_SERVERS),
    .CNT_W (CNT_W),
    .IDX_W (SRV_W)
  ) u_argmin (
    .counts       (cnt_flat),
    .eligible     (eligible),
    .start        (tie_start),
    .winner       (winner),
    .any_eligible (any_eligible)
  );

`ifdef BALANCER_RR_TIE_EN
  logic [SRV_W-1:0] rr_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (fire) begin
      rr_ptr_q <= (winner == SRV_W'(NUM_SERVERS - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign tie_start = rr_ptr_q;
`else
  assign tie_start = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_ready = (state_q == IDLE);
    case (state_q)
      IDLE:     if (accept && (tasks != '0)) state_d = DISPATCH;
      DISPATCH: if (fire && (pending_clr == '0)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else if (accept) begin
      pending_q <= tasks;
    end else if (fire) begin
      pending_q <= pending_clr;
    end
  end

  // A dispatch and a completion on the same server in one cycle cancel out.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_SERVERS; i++) begin
      inc_vec[i] = fire && (winner == SRV_W'(i));
      dec_vec[i] = done[i] && (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SERVERS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SERVERS; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dispatch_valid  <= 1'b0;
      dispatch_server <= '0;
      dispatch_task   <= '0;
    end else begin
      dispatch_valid <= fire;
      if (fire) begin
        dispatch_server <= winner;
        dispatch_task   <= top_task;
      end
    end
  end

endmodule

// File: tb/tb_multi_server_balancer.sv
// tb/tb_multi_server_balancer.sv - self-checking bench for multi_server_balancer with a behavioural model
module tb_multi_server_balancer;

  localparam int N    = 4;
  localparam int T    = 8;
  localparam int W    = 4;
  localparam int THR  = 3;
  localparam int CMAX = 15;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [T-1:0]   tasks = '0;
  logic [N-1:0]   done = '0;
  logic           dispatch_valid;
  logic [1:0]     dispatch_server;
  logic [2:0]     dispatch_task;
  logic [N*W-1:0] server_count;
  logic           trigger;
  logic           overload;

  multi_server_balancer dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .tasks           (tasks),
    .done            (done),
    .dispatch_valid  (dispatch_valid),
    .dispatch_server (dispatch_server),
    .dispatch_task   (dispatch_task),
    .server_count    (server_count),
    .trigger         (trigger),
    .overload        (overload)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: busy flag, pending set, per-server load numbers.
  bit         m_busy;
  bit [T-1:0] m_pend;
  int         m_cnt [N];
  int         m_start;
  bit         m_valid;
  int         m_srv;
  int         m_task;

  function automatic void model_reset();
    m_busy  = 0;
    m_pend  = '0;
    m_start = 0;
    m_valid = 0;
    m_srv   = 0;
    m_task  = 0;
    for (int s = 0; s < N; s++) m_cnt[s] = 0;
  endfunction

  function automatic void model_edge(input bit lv, input bit [T-1:0] t, input bit [N-1:0] d);
    bit fire = 0;
    bit found = 0;
    bit pre_busy = m_busy;
    int srv = 0;
    int tk = 0;
    int minv = CMAX;
    int s;
    if (m_busy) begin
      for (int i = 0; i < N; i++)
        if (m_cnt[i] < minv) minv = m_cnt[i];
      if (minv < CMAX) begin
        fire = 1;
`ifdef BALANCER_RR_TIE_EN
        for (int k = 0; k < N; k++) begin
          s = (m_start + k) % N;
          if (!found && m_cnt[s] == minv) begin found = 1; srv = s; end
        end
`else
        for (int i = 0; i < N; i++)
          if (!found && m_cnt[i] == minv) begin found = 1; srv = i; end
`endif
        found = 0;
        for (int b = T - 1; b >= 0; b--)
          if (!found && m_pend[b]) begin found = 1; tk = b; end
      end
    end
    for (int i = 0; i < N; i++)
      m_cnt[i] = m_cnt[i] + ((fire && i == srv) ? 1 : 0) - ((d[i] && m_cnt[i] > 0) ? 1 : 0);
    m_valid = fire;
    if (fire) begin
      m_srv   = srv;
      m_task  = tk;
      m_pend[tk] = 1'b0;
      if (m_pend == '0) m_busy = 0;
      m_start = (srv + 1) % N;
    end
    if (!pre_busy && lv) begin
      m_pend = t;
      m_busy = (t != '0);
    end
  endfunction

  task automatic cycle(input bit lv, input bit [T-1:0] t, input bit [N-1:0] d);
    load_valid = lv;
    tasks      = t;
    done       = d;
    @(posedge clk);
    model_edge(lv, t, d);
    #1;
    load_valid = 1'b0;
    tasks      = '0;
    done       = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 8'hF0, '0);
    cycle(1'b0, '0, '0);
    do_reset();
    tests_run++;
    if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", load_ready); end
    tests_run++;
    if (dispatch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", dispatch_valid); end
    tests_run++;
    if (dispatch_server !== 2'd0 || dispatch_task !== 3'd0) begin
      tests_failed++; $display("FAIL reset_dispatch got srv %0d task %0d want 0 0", dispatch_server, dispatch_task);
    end
    tests_run++;
    if (server_count !== '0) begin tests_failed++; $display("FAIL reset_counts got %h want 0", server_count); end
    tests_run++;
    if (trigger !== 1'b0 || overload !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got trig %b ovl %b want 0 0", trigger, overload);
    end
  endtask

  task automatic test_basic();
    int exp_task [3] = '{7, 5, 0};
    int exp_srv  [3] = '{0, 1, 2};
    do_reset();
    cycle(1'b1, 8'hA1, '0);
    tests_run++;
    if (dispatch_valid !== 1'b0 || load_ready !== 1'b0) begin
      tests_failed++; $display("FAIL basic_accept got valid %b ready %b want 0 0", dispatch_valid, load_ready);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, '0, '0);
      tests_run++;
      if (dispatch_valid !== 1'b1 || dispatch_task !== 3'(exp_task[k]) || dispatch_server !== 2'(exp_srv[k])) begin
        tests_failed++;
        $display("FAIL basic_pulse%0d got v%b task %0d srv %0d want v1 task %0d srv %0d",
                 k, dispatch_valid, dispatch_task, dispatch_server, exp_task[k], exp_srv[k]);
      end
    end
    tests_run++;
    if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_back got %b want 1", load_ready); end
    cycle(1'b0, '0, '0);
    tests_run++;
    if (dispatch_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_no_extra got %b want 0", dispatch_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 8'h01 << (k % 8), '0);
      cycle(1'b0, '0, '0);
    end
    for (int s = 0; s < N; s++) begin
      tests_run++;
      if (server_count[s*W +: W] !== 4'd4) begin
        tests_failed++; $display("FAIL fill_count%0d got %0d want 4", s, server_count[s*W +: W]);
      end
    end
    tests_run++;
    if (trigger !== 1'b1 || overload !== 1'b1) begin
      tests_failed++; $display("FAIL fill_flags got trig %b ovl %b want 1 1", trigger, overload);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    cycle(1'b0, '0, 4'b0010);
    tests_run++;
    if (server_count[1*W +: W] !== 4'd0) begin
      tests_failed++; $display("FAIL underflow got %0d want 0", server_count[1*W +: W]);
    end
    cycle(1'b1, 8'hFF, '0);
    for (int k = 0; k < 8; k++) cycle(1'b0, '0, '0);
    cycle(1'b1, 8'h0F, '0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0);
    cycle(1'b0, '0, 4'b0001);
    cycle(1'b1, 8'h01, '0);
    cycle(1'b0, '0, 4'b0001);
    tests_run++;
    if (dispatch_valid !== 1'b1 || dispatch_server !== 2'd0) begin
      tests_failed++; $display("FAIL same_edge_pulse got v%b srv %0d want v1 srv 0", dispatch_valid, dispatch_server);
    end
    tests_run++;
    if (server_count[0 +: W] !== 4'd2 || server_count[1*W +: W] !== 4'd3) begin
      tests_failed++; $display("FAIL same_edge_count got c0 %0d c1 %0d want 2 3", server_count[0 +: W], server_count[1*W +: W]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int r = 0; r < 7; r++) begin
      cycle(1'b1, 8'hFF, '0);
      for (int k = 0; k < 8; k++) cycle(1'b0, '0, '0);
    end
    cycle(1'b1, 8'h0F, '0);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, '0);
    tests_run++;
    if (server_count !== 16'hFFFF) begin tests_failed++; $display("FAIL stall_full got %h want ffff", server_count); end
    cycle(1'b1, 8'h01, '0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, '0, '0);
      tests_run++;
      if (dispatch_valid !== 1'b0 || load_ready !== 1'b0) begin
        tests_failed++; $display("FAIL stall_hold%0d got v%b ready %b want v0 ready 0", k, dispatch_valid, load_ready);
      end
    end
    cycle(1'b0, '0, 4'b0100);
    tests_run++;
    if (dispatch_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_done_edge got v%b want 0", dispatch_valid); end
    cycle(1'b0, '0, '0);
    tests_run++;
    if (dispatch_valid !== 1'b1 || dispatch_server !== 2'd2 || dispatch_task !== 3'd0 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_release got v%b srv %0d task %0d ready %b want v1 srv 2 task 0 ready 1",
               dispatch_valid, dispatch_server, dispatch_task, load_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 8'h1F, '0);
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, '0);
    reset = 1'b1;
    model_reset();
    #2;
    tests_run++;
    if (server_count !== '0 || load_ready !== 1'b1 || dispatch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got counts %h ready %b v%b want 0 1 0", server_count, load_ready, dispatch_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, '0, '0);
      tests_run++;
      if (dispatch_valid !== 1'b0 || load_ready !== 1'b1) begin
        tests_failed++; $display("FAIL mid_after%0d got v%b ready %b want v0 ready 1", k, dispatch_valid, load_ready);
      end
    end
  endtask

  task automatic test_tie();
`ifdef BALANCER_RR_TIE_EN
    logic [1:0] want = 2'd2;
`else
    logic [1:0] want = 2'd0;
`endif
    do_reset();
    cycle(1'b1, 8'h03, '0);
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, 4'b0011);
    tests_run++;
    if (server_count !== '0) begin tests_failed++; $display("FAIL tie_setup got %h want 0", server_count); end
    cycle(1'b1, 8'h01, '0);
    cycle(1'b0, '0, '0);
    tests_run++;
    if (dispatch_valid !== 1'b1 || dispatch_server !== want) begin
      tests_failed++; $display("FAIL tie_pick got v%b srv %0d want v1 srv %0d", dispatch_valid, dispatch_server, want);
    end
  endtask

  task automatic test_random();
    bit         lv;
    bit [T-1:0] t;
    bit [N-1:0] d;
    bit         any_hot, all_hot;
    logic [W-1:0] mc;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      lv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       t = '0;
        1:       t = 8'h01 << $urandom_range(0, 7);
        default: t = T'($urandom);
      endcase
      d = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cycle(lv, t, d);
      tests_run++;
      if (dispatch_valid !== m_valid ||
          (m_valid && (dispatch_server !== 2'(m_srv) || dispatch_task !== 3'(m_task)))) begin
        tests_failed++;
        $display("FAIL rand_dispatch c%0d got v%b srv %0d task %0d want v%b srv %0d task %0d",
                 c, dispatch_valid, dispatch_server, dispatch_task, m_valid, m_srv, m_task);
      end
      tests_run++;
      if (load_ready !== !m_busy) begin
        tests_failed++; $display("FAIL rand_ready c%0d got %b want %b", c, load_ready, !m_busy);
      end
      any_hot = 0;
      all_hot = 1;
      for (int s = 0; s < N; s++) begin
        mc = W'(m_cnt[s]);
        any_hot = any_hot | (m_cnt[s] > THR);
        all_hot = all_hot & (m_cnt[s] > THR);
        tests_run++;
        if (server_count[s*W +: W] !== mc) begin
          tests_failed++; $display("FAIL rand_count c%0d s%0d got %0d want %0d", c, s, server_count[s*W +: W], mc);
        end
      end
      tests_run++;
      if (trigger !== any_hot || overload !== all_hot) begin
        tests_failed++;
        $display("FAIL rand_flags c%0d got trig %b ovl %b want %b %b", c, trigger, overload, any_hot, all_hot);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_fill();
    test_same_edge();
    test_stall();
    test_reset_mid();
    test_tie();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_server_balancer.md
MULTI_SERVER_BALANCER -- requirements
Module: multi_server_balancer

Interface
REQ-001 SHALL have parameter NUM_SERVERS, default 4, number of servers (2..16).
REQ-002 SHALL have parameter NUM_TASKS, default 8, width of task request vector (2..32).
REQ-003 SHALL have parameter CNT_W, default 4, per-server load counter width.
REQ-004 SHALL have parameter THRESHOLD, default 3, load level above which a server counts as hot.
REQ-005 SHALL have port: clk  input  1  clock, rising edge.
REQ-006 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: load_valid  input  1  task vector offered.
REQ-008 SHALL have port: load_ready  output  1  block is idle and accepts a vector.
REQ-009 SHALL have port: tasks  input  NUM_TASKS  one bit per pending task.
REQ-010 SHALL have port: done  input  NUM_SERVERS  per-server task-completion pulse.
REQ-011 SHALL have port: dispatch_valid  output  1  one-cycle pulse per dispatched task.
REQ-012 SHALL have port: dispatch_server  output  clog2(NUM_SERVERS)  target server index.
REQ-013 SHALL have port: dispatch_task  output  clog2(NUM_TASKS)  dispatched task index.
REQ-014 SHALL have port: server_count  output  NUM_SERVERS*CNT_W  packed counters, server i at bits [i*CNT_W +: CNT_W].
REQ-015 SHALL have port: trigger  output  1  at least one server count > THRESHOLD.
REQ-016 SHALL have port: overload  output  1  every server count > THRESHOLD.

Function
REQ-017 SHALL implement states IDLE and DISPATCH; load_ready SHALL equal (state == IDLE).
REQ-018 On edge with load_valid && load_ready: nonzero tasks captured into pending register, go to DISPATCH; zero vector accepted, remain IDLE.
REQ-019 In DISPATCH, each edge with an eligible server: highest-index set pending bit cleared, least-loaded eligible server count +1, dispatch_valid/server/task registered to that task and server.
REQ-020 Dispatch rate one task per cycle; first dispatch_valid pulse one cycle after load acceptance edge; P set bits yield exactly P pulses.
REQ-021 DISPATCH -> IDLE on the edge that clears the last pending bit; load_ready high the following cycle.
REQ-022 Server eligible iff count < 2^CNT_W-1; no eligible server -> stall: no dispatch, pending held, dispatch_valid 0.
REQ-023 Ties among equal-minimum servers: lowest index wins (default, see REQ-030).
REQ-024 done[i] decrements count i on the edge; done[i] at count 0 ignored.
REQ-025 Same-edge increment and done on one server: count unchanged; done on other servers applied independently.
REQ-026 Server selection SHALL use pre-edge counts (done does not affect same-cycle selection).
REQ-027 trigger/overload SHALL be combinational functions of registered counts only.

Reset
REQ-028 reset SHALL force state IDLE, pending 0, all counts 0, dispatch_valid 0, dispatch_server 0, dispatch_task 0; trigger/overload 0 thereafter.
REQ-029 reset mid-DISPATCH SHALL discard remaining pending tasks; no dispatch pulse in the cycle after reset release.

Configuration
REQ-030 Macro BALANCER_RR_TIE_EN defined: ties resolved round-robin, search starting at (last dispatched server + 1) mod NUM_SERVERS, pointer reset to 0; undefined: REQ-023 lowest-index rule, no pointer register.

Structure
REQ-031 Package balancer_pkg SHALL hold state enum typedef and width-helper constants/functions (index widths from NUM_SERVERS, NUM_TASKS).
REQ-032 Combinational sub-module balancer_argmin SHALL take packed counts, eligibility mask, tie start index and return winner index plus any-eligible flag.
REQ-033 Top SHALL contain FSM, pending register, counters, dispatch output registers and threshold logic.

Verification
REQ-034 Defaults, tasks=8'b1010_0001 loaded -> 3 pulses on consecutive cycles: task 7->srv 0, task 5->srv 1, task 0->srv 2; load_ready returns after third.
REQ-035 Defaults, 16 single-bit loads, no done -> all counts 4, trigger 1, overload 1.
REQ-036 count0=2 (others 3), inc to srv 0 with done[0] same edge -> count0 stays 2; done[1] at count 0 -> no change, no underflow.
REQ-037 CNT_W=2, all counts 3, tasks=8'h01 -> stall, no pulse; done[2] -> next edge dispatch to srv 2.
REQ-038 reset asserted after 2 of 5 dispatches -> counts 0, load_ready 1, no further pulses.
REQ-039 BALANCER_RR_TIE_EN, all counts equal, last server 1 -> next dispatch to srv 2; undefined -> srv 0.
